// File: rtl/pipe_stage_latch.sv
// ---------------------------------------------------------------------------
// pipe_stage_latch
//
// Reusable handshaked pipeline-stage register placed between every pair of
// pipeline stages (fetch/decode, decode/execute, execute/memory,
// memory/writeback). It carries an opaque control bundle and data bundle
// with valid/ready flow control, synchronous flush, NOP insertion on
// bubbles and a saturating back-pressure (stall) counter.
//
// Build option:
//   PIPE_LATCH_SKID_EN  when defined, adds a second (skid) entry and a FULL
//                       state so the stage can absorb one extra entry under
//                       back-pressure. in_ready then comes from a flop, so
//                       there is no combinational out_ready -> in_ready path.
//                       When undefined, the stage holds a single entry and
//                       in_ready = !out_valid | out_ready (combinational).
//
// Parameters:
//   CTRL_W  control bundle width (memRead, memWrite, halt, link, jump, ...)
//   DATA_W  data bundle width (aluOut, read data, immExt, writeRegSel, ...)
//   CNT_W   stall counter width
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset, clears all state
//   flush      synchronous squash of every held entry (dominates all events)
//   in_valid   upstream presents an entry
//   in_ready   stage accepts an entry this cycle
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   out_valid  entry presented downstream (registered)
//   out_ready  downstream consumes the entry this cycle
//   out_ctrl   downstream control bundle, all-zero (NOP) while out_valid=0
//   out_data   downstream data bundle, holds its last loaded value
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_latch #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 67,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_MAIN  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Saturating increment: holds at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              vld_p1;
   logic              in_fire;
   logic              out_fire;
   logic              load_main;
   logic [CTRL_W-1:0] main_ctrl_p1;
   logic [DATA_W-1:0] main_data_p1;

`ifdef PIPE_LATCH_SKID_EN
   logic              load_skid;
   logic              main_from_skid;
   logic              in_rdy_q;
   logic [CTRL_W-1:0] skid_ctrl_p0;
   logic [DATA_W-1:0] skid_data_p0;
`endif

   assign vld_p1   = (state != ST_EMPTY);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = vld_p1 & out_ready;

`ifdef PIPE_LATCH_SKID_EN
   // Registered ready: low exactly while both entries are occupied.
   assign in_ready = in_rdy_q;
`else
   // Single entry: a new entry fits if the slot is empty or is being drained.
   assign in_ready = ~vld_p1 | out_ready;
`endif

   // Next-state and load-enable decode. Flush wins over every other event
   // and drops any entry handed over in the same cycle.
   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
`ifdef PIPE_LATCH_SKID_EN
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
`endif
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt = ST_MAIN;
                  load_main = 1'b1;
               end
            end
            ST_MAIN: begin
`ifdef PIPE_LATCH_SKID_EN
               if (in_fire && out_ready) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  // Downstream stalled: park the new entry behind MAIN.
                  state_nxt = ST_FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
`else
               // in_fire implies out_ready here, so MAIN is replaced in place.
               if (in_fire) begin
                  load_main = 1'b1;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
`endif
            end
`ifdef PIPE_LATCH_SKID_EN
            ST_FULL: begin
               if (out_fire) begin
                  state_nxt      = ST_MAIN;
                  main_from_skid = 1'b1;
               end
            end
`endif
            default: begin
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

`ifdef PIPE_LATCH_SKID_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_rdy_q <= 1'b1;
      end else begin
         in_rdy_q <= (state_nxt != ST_FULL);
      end
   end

   // ---- stage p0: skid entry, filled only while downstream is stalled ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_ctrl_p0 <= '0;
         skid_data_p0 <= '0;
      end else if (load_skid) begin
         skid_ctrl_p0 <= in_ctrl;
         skid_data_p0 <= in_data;
      end
   end
`endif

   // ---- stage p1: main entry, drives the downstream outputs ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_ctrl_p1 <= '0;
         main_data_p1 <= '0;
      end else if (load_main) begin
         main_ctrl_p1 <= in_ctrl;
         main_data_p1 <= in_data;
`ifdef PIPE_LATCH_SKID_EN
      end else if (main_from_skid) begin
         main_ctrl_p1 <= skid_ctrl_p0;
         main_data_p1 <= skid_data_p0;
`endif
      end
   end

   // Stall counter is cleared only by reset; flush leaves it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (vld_p1 && !out_ready) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign out_valid = vld_p1;
   // Bubbles present a NOP control word; data is left as-is to save toggling.
   assign out_ctrl  = vld_p1 ? main_ctrl_p1 : '0;
   assign out_data  = main_data_p1;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_latch
//
// Directed bench for pipe_stage_latch. Uses CNT_W=4 so counter saturation is
// reachable quickly. Builds with or without PIPE_LATCH_SKID_EN; the vector
// table picks the matching back-pressure sequence.
// ---------------------------------------------------------------------------
module tb_pipe_stage_latch;

   localparam int CTRL_W = 8;
   localparam int DATA_W = 67;
   localparam int CNT_W  = 4;

`ifdef PIPE_LATCH_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic              fl;
      logic              iv;
      logic [CTRL_W-1:0] ic;
      logic [DATA_W-1:0] id;
      logic              ordy;
      logic              ov;
      logic [CTRL_W-1:0] oc;
      logic [DATA_W-1:0] od;
      logic              irdy;
      logic [CNT_W-1:0]  sc;
   } vec_t;

   vec_t tbl[$];

   pipe_stage_latch #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_ctrl  (in_ctrl),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ctrl (out_ctrl),
      .out_data (out_data),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic iv, input logic [CTRL_W-1:0] ic,
                               input logic [DATA_W-1:0] id, input logic ordy,
                               input logic ov, input logic [CTRL_W-1:0] oc,
                               input logic [DATA_W-1:0] od, input logic irdy,
                               input logic [CNT_W-1:0] sc);
      vec_t v;
      v.fl = fl; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
      v.ov = ov; v.oc = oc; v.od = od; v.irdy = irdy; v.sc = sc;
      return v;
   endfunction

   task automatic chk_all(input string tag, input logic ov, input logic [CTRL_W-1:0] oc,
                          input logic [DATA_W-1:0] od, input logic irdy,
                          input logic [CNT_W-1:0] sc);
      chk({tag, " out_valid"}, 128'(out_valid), 128'(ov));
      chk({tag, " out_ctrl"},  128'(out_ctrl),  128'(oc));
      chk({tag, " out_data"},  128'(out_data),  128'(od));
      chk({tag, " in_ready"},  128'(in_ready),  128'(irdy));
      chk({tag, " stall_cnt"}, 128'(stall_cnt), 128'(sc));
   endtask

   initial begin
      // Table: streaming, back-pressure, drain, flush. Each row is applied,
      // one rising edge passes, then outputs are compared.
      for (int i = 0; i < 10; i++) begin
         tbl.push_back(mk(0, 1, 8'(8'h10 + i), 67'(i), 1,
                          1, 8'(8'h10 + i), 67'(i), 1, 4'd0));
      end
`ifdef PIPE_LATCH_SKID_EN
      tbl.push_back(mk(0, 1, 8'hA1, 67'd100, 0,  1, 8'h19, 67'd9,   0, 4'd1));
      tbl.push_back(mk(0, 1, 8'hA2, 67'd101, 0,  1, 8'h19, 67'd9,   0, 4'd2));
      tbl.push_back(mk(0, 1, 8'hA2, 67'd101, 1,  1, 8'hA1, 67'd100, 1, 4'd2));
      tbl.push_back(mk(0, 1, 8'hA2, 67'd101, 1,  1, 8'hA2, 67'd101, 1, 4'd2));
`else
      tbl.push_back(mk(0, 1, 8'hA1, 67'd100, 0,  1, 8'h19, 67'd9,   0, 4'd1));
      tbl.push_back(mk(0, 1, 8'hA1, 67'd100, 1,  1, 8'hA1, 67'd100, 1, 4'd1));
      tbl.push_back(mk(0, 1, 8'hA2, 67'd101, 0,  1, 8'hA1, 67'd100, 0, 4'd2));
      tbl.push_back(mk(0, 1, 8'hA2, 67'd101, 1,  1, 8'hA2, 67'd101, 1, 4'd2));
`endif
      tbl.push_back(mk(0, 0, 8'h00, 67'd0,   1,  0, 8'h00, 67'd101, 1, 4'd2));
      tbl.push_back(mk(0, 0, 8'h00, 67'd0,   0,  0, 8'h00, 67'd101, 1, 4'd2));
      tbl.push_back(mk(0, 1, 8'hB1, 67'd200, 0,  1, 8'hB1, 67'd200, SKID, 4'd2));
      tbl.push_back(mk(1, 1, 8'hB2, 67'd201, 0,  0, 8'h00, 67'd200, 1, 4'd3));
      tbl.push_back(mk(0, 1, 8'hB3, 67'd202, 1,  1, 8'hB3, 67'd202, 1, 4'd3));
      tbl.push_back(mk(1, 1, 8'hB4, 67'd203, 1,  0, 8'h00, 67'd202, 1, 4'd3));
      tbl.push_back(mk(1, 1, 8'hB5, 67'd204, 1,  0, 8'h00, 67'd202, 1, 4'd3));
      tbl.push_back(mk(0, 0, 8'h00, 67'd0,   1,  0, 8'h00, 67'd202, 1, 4'd3));
`ifdef PIPE_LATCH_SKID_EN
      tbl.push_back(mk(0, 1, 8'hD1, 67'd300, 0,  1, 8'hD1, 67'd300, 1, 4'd3));
      tbl.push_back(mk(0, 1, 8'hD2, 67'd301, 0,  1, 8'hD1, 67'd300, 0, 4'd4));
      tbl.push_back(mk(1, 1, 8'hD3, 67'd302, 1,  0, 8'h00, 67'd300, 1, 4'd4));
      tbl.push_back(mk(0, 1, 8'hD4, 67'd303, 1,  1, 8'hD4, 67'd303, 1, 4'd4));
      tbl.push_back(mk(0, 0, 8'h00, 67'd0,   1,  0, 8'h00, 67'd303, 1, 4'd4));
`endif

      // Reset asserted with an entry offered: outputs must clear without a clock.
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 8'hFF;
      in_data   = 67'h55;
      out_ready = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_reset", 1'b0, 8'h00, 67'd0, 1'b1, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("held_reset", 1'b0, 8'h00, 67'd0, 1'b1, 4'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_all("first_load", 1'b1, 8'hFF, 67'h55, 1'b1, 4'd0);

      for (int k = 0; k < tbl.size(); k++) begin
         flush     = tbl[k].fl;
         in_valid  = tbl[k].iv;
         in_ctrl   = tbl[k].ic;
         in_data   = tbl[k].id;
         out_ready = tbl[k].ordy;
         @(posedge clk);
         #1;
         chk_all($sformatf("v%0d", k), tbl[k].ov, tbl[k].oc, tbl[k].od, tbl[k].irdy, tbl[k].sc);
      end

      // Counter saturation: fresh reset, one entry held against back-pressure.
      flush    = 1'b0;
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      chk("sat_reset stall_cnt", 128'(stall_cnt), 128'(0));
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 8'h5A;
      in_data   = 67'd77;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_all("sat_load", 1'b1, 8'h5A, 67'd77, SKID, 4'd0);
      in_valid = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("sat_14 stall_cnt", 128'(stall_cnt), 128'(14));
      // In the single-entry build in_ready follows out_ready combinationally.
      chk("mirror_lo in_ready", 128'(in_ready), 128'(SKID));
      out_ready = 1'b1;
      #1;
      chk("mirror_hi in_ready", 128'(in_ready), 128'(1));
      out_ready = 1'b0;
      #1;
      chk("mirror_back in_ready", 128'(in_ready), 128'(SKID));
      @(posedge clk);
      #1;
      chk("sat_15 stall_cnt", 128'(stall_cnt), 128'(15));
      repeat (5) @(posedge clk);
      #1;
      chk_all("sat_hold", 1'b1, 8'h5A, 67'd77, SKID, 4'd15);

      // Reset mid-operation together with flush: reset wins, no edge needed.
      flush = 1'b1;
      rst   = 1'b0;
      #1;
      chk_all("midop_reset", 1'b0, 8'h00, 67'd0, 1'b1, 4'd0);
      @(posedge clk);
      #1;
      rst   = 1'b1;
      flush = 1'b0;
      @(posedge clk);
      #1;
      chk_all("post_reset", 1'b0, 8'h00, 67'd0, 1'b1, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_latch.md
# pipe_stage_latch

Parametrised, handshaked pipeline-stage register that generalises the fixed per-stage latches (fetch/decode, decode/execute, execute/memory, memory/writeback) into one reusable block. It carries a control bundle and a data bundle of configurable widths with valid/ready flow control, synchronous flush, NOP insertion on bubbles, an optional two-entry skid buffer, and a saturating stall counter. The block is instantiated between every pair of pipeline stages.

## Interface
Parameters:
- CTRL_W, 8, control bundle width (memRead, memWrite, halt, link, jump, … packed by the instantiating stage)
- DATA_W, 67, data bundle width (e.g. aluOut + read1/read2 data + immExt + writeRegSel)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  block accepts an entry this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream consumes the entry this cycle
- out_ctrl  out  CTRL_W  downstream control bundle; all-zero (NOP) whenever out_valid=0
- out_data  out  DATA_W  downstream data bundle
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: MAIN entry (drives outputs); SKID entry only when PIPE_LATCH_SKID_EN defined.
- State machine: EMPTY, MAIN, FULL (FULL exists only with skid).
  - EMPTY: in_fire → MAIN, MAIN ← in.
  - MAIN: in_fire & out_fire → MAIN, MAIN ← in; in_fire & !out_ready → FULL, SKID ← in; out_fire & !in_fire → EMPTY.
  - FULL: in_ready=0; out_fire → MAIN, MAIN ← SKID.
- out_valid = (state != EMPTY).
- NOP insertion: out_ctrl forced to 0 when out_valid=0; out_data holds its last loaded value (not cleared).
- Flush: next state EMPTY regardless of state, in_valid, out_ready; any same-cycle in_fire entry is dropped. Flush dominates all other events.
- stall_cnt: increments when out_valid & !out_ready, saturates at 2^CNT_W−1, never wraps; cleared only by rst (flush does not clear it).

## Timing
- Reset values: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1.
- Latency: entry accepted at edge N is on outputs after edge N (visible cycle N+1); one cycle, no bubbles at full throughput.
- Throughput: one entry per cycle while out_ready=1.
- Outputs out_valid/out_ctrl/out_data are registered; no combinational in→out path.
- rst assertion mid-operation: all entries discarded immediately (asynchronous), outputs take reset values without a clock edge.
- Simultaneous flush & rst: rst wins.

## Configuration
- PIPE_LATCH_SKID_EN defined: SKID entry and FULL state present; in_ready is registered, = (next state != FULL); no combinational out_ready→in_ready path; absorbs one extra entry under back-pressure.
- PIPE_LATCH_SKID_EN undefined: single entry, states EMPTY/MAIN only; in_ready = !out_valid | out_ready (combinational); in MAIN with in_fire & !out_ready impossible by construction.

## Test plan
- Reset: drive rst=0 with in_valid=1, in_ctrl=8'hFF → out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1; release, first edge loads entry, out_ctrl=8'hFF next cycle.
- Streaming: 10 back-to-back entries (data=0..9), out_ready=1 → out_data 0..9 on consecutive cycles, one-cycle latency, in_ready constantly 1.
- Back-pressure (SKID_EN): out_ready=0, push A then B → state FULL, in_ready=0, C held upstream; raise out_ready → A, B, C in order, no loss or duplication; stall_cnt equals stalled cycles.
- Flush in FULL with in_valid=1: next cycle out_valid=0, out_ctrl=0, incoming entry dropped, in_ready=1; stall_cnt unchanged.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15.
- No-skid build: out_ready toggling 1,0,1 with continuous in_valid → in_ready mirrors out_ready in the same cycle while MAIN; order preserved.
